// File: rtl/multiplier_datapath_pkg.sv
// Shared constants and command encoding for the shift-add multiplier datapath.
package mult_pkg;

    localparam int WIDTH  = 4;
    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int PROD_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        CMD_NONE      = 2'b00,
        CMD_ADD       = 2'b01,
        CMD_SHIFT     = 2'b10,
        CMD_ADD_SHIFT = 2'b11
    } cmd_t;

    function automatic cmd_t decode_cmd(input logic add_cmd, input logic shift_cmd);
        return cmd_t'({shift_cmd, add_cmd});
    endfunction

endpackage

// File: rtl/multiplier_datapath_if.sv
// Product output handshake between the datapath (master) and its consumer (slave).
interface multiplier_datapath_if #(
    parameter int WIDTH = mult_pkg::WIDTH
);
    logic [2*WIDTH-1:0] product;
    logic               product_valid;
    logic               product_ready;

    modport master (output product, output product_valid, input product_ready);
    modport slave  (input product, input product_valid, output product_ready);
endinterface

// File: rtl/mult_result_buffer.sv
// One-entry valid/ready holding register; flags a sticky overrun when a capture
// arrives while the entry is full and not being drained.
module mult_result_buffer #(
    parameter int DATA_W = mult_pkg::PROD_W
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              capture,
    input  logic [DATA_W-1:0] data,
    input  logic              ready,
    output logic [DATA_W-1:0] product,
    output logic              valid,
    output logic              overrun
);

    logic space_ok;
    assign space_ok = ~valid | ready;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            product <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else if (capture) begin
            if (space_ok) begin
                product <= data;
                valid   <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/multiplier_datapath.sv
// Shift-add multiplier datapath: C/A/Q/M registers driven by controller commands,
// with the finished product captured into a one-entry handshake buffer.
module multiplier_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = mult_pkg::WIDTH
) (
    input  logic                 Clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 Load_cmd,
    input  logic                 Add_cmd,
    input  logic                 Shift_cmd,
    input  logic                 STOP,
    output logic                 lsb,
    output logic                 busy,
    output logic                 overrun,
    output logic                 shift_err,
    multiplier_datapath_if.master result
);

    localparam int CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(WIDTH);

    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] q_reg;
    logic             c_reg;
    logic [CntW-1:0]  shift_cnt;
    logic             stop_d;
    logic [WIDTH:0]   sum;
    logic             stop_rise;
    logic             capture;
    logic             cnt_full;
    cmd_t             cmd;

    assign sum       = {1'b0, a_reg} + {1'b0, m_reg};
    assign cmd       = decode_cmd(Add_cmd, Shift_cmd);
    assign cnt_full  = (shift_cnt == CntMax);
    assign stop_rise = STOP & ~stop_d;
    assign capture   = stop_rise & busy & cnt_full;
    assign lsb       = q_reg[0];

    // Once the counter saturates, shifts (with or without an add) leave the registers alone.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            m_reg     <= '0;
            a_reg     <= '0;
            q_reg     <= '0;
            c_reg     <= 1'b0;
            shift_cnt <= '0;
            stop_d    <= 1'b0;
            busy      <= 1'b0;
            shift_err <= 1'b0;
        end else begin
            stop_d <= STOP;
            if (Load_cmd) begin
                m_reg     <= multiplicand;
                q_reg     <= multiplier;
                a_reg     <= '0;
                c_reg     <= 1'b0;
                shift_cnt <= '0;
                busy      <= 1'b1;
            end else begin
                if (capture) begin
                    busy <= 1'b0;
                end
                case (cmd)
                    CMD_ADD: begin
                        {c_reg, a_reg} <= sum;
                    end
                    CMD_SHIFT: begin
                        if (cnt_full) begin
                            shift_err <= 1'b1;
                        end else begin
                            {c_reg, a_reg, q_reg} <= {1'b0, c_reg, a_reg, q_reg[WIDTH-1:1]};
                            shift_cnt             <= shift_cnt + CntW'(1);
                        end
                    end
                    CMD_ADD_SHIFT: begin
                        if (cnt_full) begin
                            shift_err <= 1'b1;
                        end else begin
                            {c_reg, a_reg, q_reg} <= {1'b0, sum, q_reg[WIDTH-1:1]};
                            shift_cnt             <= shift_cnt + CntW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    mult_result_buffer #(
        .DATA_W (2*WIDTH)
    ) u_result_buffer (
        .Clk     (Clk),
        .reset   (reset),
        .capture (capture),
        .data    ({a_reg, q_reg}),
        .ready   (result.product_ready),
        .product (result.product),
        .valid   (result.product_valid),
        .overrun (overrun)
    );

endmodule

// File: tb/tb_multiplier_datapath.sv
// Directed bench for multiplier_datapath: drives the controller command sequence
// and checks outputs against hand-computed products and flag values.
module tb_multiplier_datapath;

    logic       Clk;
    logic       reset;
    logic [3:0] multiplicand;
    logic [3:0] multiplier;
    logic       Load_cmd;
    logic       Add_cmd;
    logic       Shift_cmd;
    logic       STOP;
    logic       lsb;
    logic       busy;
    logic       overrun;
    logic       shift_err;
    int         tests;
    int         fails;

    multiplier_datapath_if #(.WIDTH(4)) out_if ();

    multiplier_datapath #(.WIDTH(4)) dut (
        .Clk          (Clk),
        .reset        (reset),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .Load_cmd     (Load_cmd),
        .Add_cmd      (Add_cmd),
        .Shift_cmd    (Shift_cmd),
        .STOP         (STOP),
        .lsb          (lsb),
        .busy         (busy),
        .overrun      (overrun),
        .shift_err    (shift_err),
        .result       (out_if.master)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Acts as the controller: load, then four iterations of add-on-lsb and shift.
    task automatic applyStimulus(input logic [3:0] mcand, input logic [3:0] mplier,
                                 input bit combined, input int n_shifts);
        multiplicand = mcand;
        multiplier   = mplier;
        Load_cmd     = 1'b1;
        tick();
        Load_cmd = 1'b0;
        for (int i = 0; i < n_shifts; i++) begin
            if (combined) begin
                Add_cmd   = lsb;
                Shift_cmd = 1'b1;
                tick();
            end else begin
                if (lsb) begin
                    Add_cmd = 1'b1;
                    tick();
                    Add_cmd = 1'b0;
                end
                Shift_cmd = 1'b1;
                tick();
            end
            Add_cmd   = 1'b0;
            Shift_cmd = 1'b0;
        end
    endtask

    task automatic raiseStop(input logic rdy);
        STOP                 = 1'b1;
        out_if.product_ready = rdy;
        tick();
        out_if.product_ready = 1'b0;
    endtask

    task automatic lowerStop();
        STOP = 1'b0;
        tick();
    endtask

    initial begin
        tests                = 0;
        fails                = 0;
        reset                = 1'b0;
        multiplicand         = '0;
        multiplier           = '0;
        Load_cmd             = 1'b0;
        Add_cmd              = 1'b0;
        Shift_cmd            = 1'b0;
        STOP                 = 1'b0;
        out_if.product_ready = 1'b0;
        tick();
        tick();
        checkOutput("reset_product", 32'(out_if.product), 32'h00);
        checkOutput("reset_valid", 32'(out_if.product_valid), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_lsb", 32'(lsb), 32'h0);
        checkOutput("reset_flags", 32'({overrun, shift_err}), 32'h0);
        @(negedge Clk);
        reset = 1'b1;
        tick();

        // 5 x 11 = 55 with separate add and shift cycles
        applyStimulus(4'd5, 4'd11, 1'b0, 4);
        checkOutput("op1_busy_before_stop", 32'(busy), 32'h1);
        checkOutput("op1_valid_before_stop", 32'(out_if.product_valid), 32'h0);
        raiseStop(1'b0);
        checkOutput("op1_product", 32'(out_if.product), 32'h37);
        checkOutput("op1_valid", 32'(out_if.product_valid), 32'h1);
        checkOutput("op1_busy", 32'(busy), 32'h0);
        lowerStop();

        // 15 x 15 = 225 with combined cycles, draining 0x37 on the capture cycle
        applyStimulus(4'd15, 4'd15, 1'b1, 4);
        raiseStop(1'b1);
        checkOutput("op2_product", 32'(out_if.product), 32'hE1);
        checkOutput("op2_valid", 32'(out_if.product_valid), 32'h1);
        checkOutput("op2_overrun", 32'(overrun), 32'h0);
        lowerStop();
        out_if.product_ready = 1'b1;
        tick();
        out_if.product_ready = 1'b0;
        checkOutput("op2_drained", 32'(out_if.product_valid), 32'h0);

        // 15 x 9 = 135 held, then 1 x 3 completes into a full buffer
        applyStimulus(4'd15, 4'd9, 1'b0, 4);
        raiseStop(1'b0);
        checkOutput("op3_product", 32'(out_if.product), 32'h87);
        lowerStop();
        applyStimulus(4'd1, 4'd3, 1'b0, 4);
        raiseStop(1'b0);
        checkOutput("op4_product_kept", 32'(out_if.product), 32'h87);
        checkOutput("op4_overrun", 32'(overrun), 32'h1);
        checkOutput("op4_busy", 32'(busy), 32'h0);
        checkOutput("op4_valid", 32'(out_if.product_valid), 32'h1);
        lowerStop();
        out_if.product_ready = 1'b1;
        tick();
        out_if.product_ready = 1'b0;
        checkOutput("op4_drained", 32'(out_if.product_valid), 32'h0);

        // 3 x 5 = 15, then a fifth shift must be ignored
        applyStimulus(4'd3, 4'd5, 1'b0, 4);
        checkOutput("op5_shift_err_clear", 32'(shift_err), 32'h0);
        Shift_cmd = 1'b1;
        tick();
        Shift_cmd = 1'b0;
        checkOutput("op5_shift_err", 32'(shift_err), 32'h1);
        checkOutput("op5_lsb", 32'(lsb), 32'h1);
        raiseStop(1'b0);
        checkOutput("op5_product", 32'(out_if.product), 32'h0F);
        lowerStop();

        // STOP rise after only two shifts: no capture, still busy
        applyStimulus(4'd7, 4'd6, 1'b0, 2);
        raiseStop(1'b0);
        checkOutput("op6_busy", 32'(busy), 32'h1);
        checkOutput("op6_product_kept", 32'(out_if.product), 32'h0F);
        lowerStop();

        // Asynchronous reset between edges mid-operation
        applyStimulus(4'd7, 4'd13, 1'b0, 2);
        checkOutput("op7_lsb_before_reset", 32'(lsb), 32'h1);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("async_product", 32'(out_if.product), 32'h00);
        checkOutput("async_valid", 32'(out_if.product_valid), 32'h0);
        checkOutput("async_busy", 32'(busy), 32'h0);
        checkOutput("async_lsb", 32'(lsb), 32'h0);
        checkOutput("async_flags", 32'({overrun, shift_err}), 32'h0);
        @(negedge Clk);
        reset = 1'b1;
        raiseStop(1'b0);
        checkOutput("post_reset_valid", 32'(out_if.product_valid), 32'h0);
        checkOutput("post_reset_busy", 32'(busy), 32'h0);
        lowerStop();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
